apb4_master_arbiter: RTL and testbench

- Shares one APB4 master port between `NUM_REQ` local requesters using round-robin arbitration.
- Sequences each granted transfer through the APB4 IDLE/SETUP/ACCESS protocol and returns the read data and error status to the requester that issued it.
- Sits in front of the APB4 register-file slaves; its APB outputs drive `PSELx`/`PENABLE`/`PADDR` of the selected slave.

---
 rtl/apb4_pkg.sv | 17 +
 rtl/apb4_rr_arbiter.sv | 46 ++++
 rtl/apb4_master_arbiter.sv | 170 +++++++++++++++++
 tb/tb_apb4_master_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_pkg.sv
// apb4_pkg: shared state encoding and sizing helpers
// for the APB4 master arbiter.
package apb4_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 16;

  function automatic int STRB_WIDTH(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/apb4_rr_arbiter.sv
// apb4_rr_arbiter: one-hot round-robin grant with a
// last_grant pointer advanced on each accepted update.
module apb4_rr_arbiter
  import apb4_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] last_grant;
  logic [IW-1:0] gidx;
  logic          found;

  // search starts one past the previous winner and wraps
  always_comb begin
    int idx;
    grant = '0;
    gidx  = last_grant;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        gidx  = idx[IW-1:0];
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IW'(NUM_REQ - 1);
    end else if (update && found) begin
      last_grant <= gidx;
    end
  end

endmodule

// File: rtl/apb4_master_arbiter.sv
// apb4_master_arbiter: round-robin share of one APB4 master port.
// Optional ACCESS timeout is built when APB4_ARB_TIMEOUT_EN is defined.
module apb4_master_arbiter
  import apb4_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  output logic                             PSEL,
  output logic                             PENABLE,
  input  logic                             PREADY,
  input  logic [DATA_WIDTH-1:0]            PRDATA,
  input  logic                             PSLVERR
);

  localparam int SW = STRB_WIDTH(DATA_WIDTH);

  apb_state_e state, state_nxt;

  logic               any_req;
  logic               done;
  logic               abort;
  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] owner;

  logic [ADDR_WIDTH-1:0] g_addr;
  logic                  g_write;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic [SW-1:0]         g_strb;

  assign any_req = |req_valid;
  assign done    = (state == APB_ACCESS) && PREADY;
  assign arb_en  = (state == APB_IDLE) || done;

  // the grant pulse is combinational, so mask it during reset
  assign req_ready = (arb_en && !PRESET) ? grant : '0;

  apb4_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk    (PCLK),
    .rst    (PRESET),
    .req    (req_valid),
    .update (arb_en),
    .grant  (grant)
  );

`ifdef APB4_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tmo_cnt <= '0;
    end else if (state == APB_SETUP) begin
      tmo_cnt <= '0;
    end else if (state == APB_ACCESS && !PREADY) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // a late PREADY in the limit cycle still completes normally
  assign abort = (state == APB_ACCESS) && !PREADY &&
                 (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYCLES;
  assign abort      = 1'b0;
`endif

  always_comb begin
    g_addr  = '0;
    g_write = 1'b0;
    g_wdata = '0;
    g_strb  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        g_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        g_write = req_write[i];
        g_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        g_strb  = req_strb[i*SW +: SW];
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= APB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    unique case (state)
      APB_IDLE: begin
        if (any_req) state_nxt = APB_SETUP;
      end
      APB_SETUP: begin
        PSEL      = 1'b1;
        state_nxt = APB_ACCESS;
      end
      APB_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          state_nxt = any_req ? APB_SETUP : APB_IDLE;
        end else if (abort) begin
          state_nxt = APB_IDLE;
        end
      end
      default: state_nxt = APB_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      owner     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (|req_ready) begin
        PADDR  <= g_addr;
        PWRITE <= g_write;
        PWDATA <= g_wdata;
        PSTRB  <= g_write ? g_strb : '0;
        owner  <= grant;
      end
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (done) begin
        rsp_valid <= owner;
        rsp_rdata <= PWRITE ? '0 : PRDATA;
        rsp_err   <= PSLVERR;
      end else if (abort) begin
        rsp_valid <= owner;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb4_master_arbiter.sv
// tb_apb4_master_arbiter: directed and random transfers against
// a transaction-timeline reference model and a register-file slave.
module tb_apb4_master_arbiter;
  import apb4_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NR  = 2;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;
`ifdef APB4_ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_write;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*SW-1:0] req_strb;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic [AW-1:0]    PADDR;
  logic             PWRITE;
  logic [DW-1:0]    PWDATA;
  logic [SW-1:0]    PSTRB;
  logic             PSEL;
  logic             PENABLE;
  logic             PREADY;
  logic [DW-1:0]    PRDATA;
  logic             PSLVERR;

  apb4_master_arbiter #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int            cyc;
    int            g;
    logic [DW-1:0] rd;
    logic          err;
  } rsp_t;

  int n_vec = 0;
  int n_bad = 0;

  logic          pend  [NR];
  logic [AW-1:0] r_addr[NR];
  logic          r_wr  [NR];
  logic [DW-1:0] r_wd  [NR];
  logic [SW-1:0] r_st  [NR];
  int            r_w   [NR];

  logic [DW-1:0] smem[16];
  logic [DW-1:0] gmem[16];

  int            cyc;
  logic          m_busy;
  int            m_tg, m_end;
  logic          m_abort;
  int            m_last;
  logic [AW-1:0] m_addr;
  logic          m_wr;
  logic [DW-1:0] m_wd;
  logic [SW-1:0] m_st;
  int            cur_w;
  int            acc_idx;
  rsp_t          rq[$];
  int            gnt_log[$];
  logic [DW-1:0] last_rd;
  logic          last_err;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o,
                                          input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = o;
    for (int b = 0; b < SW; b++)
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic bit model_busy();
    bit b;
    b = m_busy || (rq.size() != 0);
    for (int i = 0; i < NR; i++) b |= pend[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    m_busy  = 1'b0;
    m_abort = 1'b0;
    m_last  = NR - 1;
    acc_idx = 0;
    cur_w   = 1;
    rq.delete();
  endtask

  task automatic req(input int i, input logic [AW-1:0] a,
                     input logic w, input logic [DW-1:0] d,
                     input logic [SW-1:0] s, input int wt);
    pend[i]   = 1'b1;
    r_addr[i] = a;
    r_wr[i]   = w;
    r_wd[i]   = d;
    r_st[i]   = s;
    r_w[i]    = wt;
  endtask

  task automatic step();
    logic [NR-1:0] vv, eg, erv;
    logic          esel, een;
    int            g;
    rsp_t          r;
    @(posedge PCLK);
    cyc++;
    #1;
    // register-file slave: ready after cur_w extra ACCESS cycles
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = $urandom;
    if (PSEL && PENABLE) begin
      if (acc_idx == cur_w) begin
        PREADY  = 1'b1;
        PSLVERR = (PADDR[1:0] != 2'b00);
        if (!PWRITE) PRDATA = smem[PADDR[5:2]];
        else if (!PSLVERR)
          smem[PADDR[5:2]] = merge(smem[PADDR[5:2]], PWDATA, PSTRB);
      end
      acc_idx++;
    end else begin
      acc_idx = 0;
    end
    for (int i = 0; i < NR; i++) begin
      req_valid[i]            = pend[i];
      req_addr[i*AW +: AW]    = r_addr[i];
      req_write[i]            = r_wr[i];
      req_wdata[i*DW +: DW]   = r_wd[i];
      req_strb[i*SW +: SW]    = r_st[i];
    end
    @(negedge PCLK);
    for (int i = 0; i < NR; i++) vv[i] = pend[i];
    esel = 1'b0;
    een  = 1'b0;
    if (m_busy && cyc == m_tg + 1) begin
      esel = 1'b1;
    end else if (m_busy && cyc >= m_tg + 2 && cyc <= m_end) begin
      esel = 1'b1;
      een  = 1'b1;
    end
    erv = '0;
    if (rq.size() != 0 && rq[0].cyc == cyc) erv[rq[0].g] = 1'b1;
    eg = '0;
    g  = -1;
    if ((!m_busy || (cyc == m_end && !m_abort)) && |vv) begin
      for (int k = 1; k <= NR; k++) begin
        int j;
        j = (m_last + k) % NR;
        if (g < 0 && vv[j]) g = j;
      end
      eg[g] = 1'b1;
    end
    chk("psel", PSEL, esel);
    chk("penable", PENABLE, een);
    chk("req_ready", req_ready, eg);
    chk("rsp_valid", rsp_valid, erv);
    if (erv != 0) begin
      chk("rsp_rdata", rsp_rdata, rq[0].rd);
      chk("rsp_err", rsp_err, rq[0].err);
      void'(rq.pop_front());
    end
    if (rsp_valid != 0) begin
      last_rd  = rsp_rdata;
      last_err = rsp_err;
    end
    if (esel && !een) begin
      chk("paddr", PADDR, m_addr);
      chk("pwrite", PWRITE, m_wr);
      chk("pstrb", PSTRB, m_wr ? m_st : '0);
      if (m_wr) chk("pwdata", PWDATA, m_wd);
    end
    if (m_busy && cyc == m_end) m_busy = 1'b0;
    if (g >= 0) begin
      m_last = g;
      gnt_log.push_back(g);
      pend[g] = 1'b0;
      m_addr  = r_addr[g];
      m_wr    = r_wr[g];
      m_wd    = r_wd[g];
      m_st    = r_st[g];
      cur_w   = r_w[g];
      m_busy  = 1'b1;
      m_tg    = cyc;
      r.g     = g;
      if (TMO_ON && cur_w >= TMO) begin
        m_abort = 1'b1;
        m_end   = cyc + 1 + TMO;
        r.rd    = '0;
        r.err   = 1'b1;
      end else begin
        m_abort = 1'b0;
        m_end   = cyc + 2 + cur_w;
        r.err   = (m_addr[1:0] != 2'b00);
        r.rd    = m_wr ? '0 : gmem[m_addr[5:2]];
        if (m_wr && !r.err)
          gmem[m_addr[5:2]] = merge(gmem[m_addr[5:2]], m_wd, m_st);
      end
      r.cyc = m_end + 1;
      rq.push_back(r);
    end
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (model_busy() && n < maxc) begin
      step();
      n++;
    end
    chk("drain_bound", n < maxc, 1);
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESET = 1'b1;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int reps[NR];
    PRESET    = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_wdata = '0;
    req_strb  = '0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    PSLVERR   = 1'b0;
    cyc       = 0;
    last_rd   = '0;
    last_err  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      smem[i] = '0;
      gmem[i] = '0;
    end
    for (int i = 0; i < NR; i++) req(i, '0, 1'b0, '0, '0, 1);
    model_reset();
    #2 PRESET = 1'b1;
    #2;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pstrb", PSTRB, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;

    // write then read across requesters
    req(0, 32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 1);
    drain(20);
    req(1, 32'h04, 1'b0, '0, 4'hF, 1);
    drain(20);
    chk("wr_rd_data", last_rd, 32'hDEADBEEF);
    chk("wr_rd_err", last_err, 0);

    // partial strobe merge
    req(0, 32'h08, 1'b1, 32'h11223344, 4'hF, 1);
    drain(20);
    req(0, 32'h08, 1'b1, 32'hAABBCCDD, 4'h3, 1);
    drain(20);
    req(1, 32'h08, 1'b0, 32'hFFFFFFFF, 4'hF, 1);
    drain(20);
    chk("strb_data", last_rd, 32'h1122CCDD);

    // round robin: each requester re-asserts right after its grant
    do_reset();
    gnt_log.delete();
    reps[0] = 1;
    reps[1] = 1;
    req(0, 32'h04, 1'b0, '0, '0, 1);
    req(1, 32'h08, 1'b0, '0, '0, 1);
    for (int n = 0; n < 40 && gnt_log.size() < 4; n++) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && reps[i] > 0) begin
          req(i, 32'h04, 1'b0, '0, '0, 1);
          reps[i]--;
        end
      end
    end
    drain(30);
    chk("rr_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
      chk("rr_g0", gnt_log[0], 0);
      chk("rr_g1", gnt_log[1], 1);
      chk("rr_g2", gnt_log[2], 0);
      chk("rr_g3", gnt_log[3], 1);
    end

    // misaligned read
    req(1, 32'h06, 1'b0, '0, '0, 1);
    drain(20);
    chk("mis_err", last_err, 1);
    chk("mis_idle", PSEL, 0);

    // reset during ACCESS
    req(0, 32'h04, 1'b0, '0, '0, 1);
    repeat (3) step();
    chk("mid_in_access", PENABLE, 1);
    #2 PRESET = 1'b1;
    #1;
    chk("mid_psel", PSEL, 0);
    chk("mid_penable", PENABLE, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("mid_hold_rsp", rsp_valid, 0);
    PRESET = 1'b0;
    model_reset();
    req(1, 32'h04, 1'b0, '0, '0, 1);
    drain(20);
    chk("post_rst_data", last_rd, 32'hDEADBEEF);

    // stalled slave: aborts only when the timeout is built
    req(0, 32'h0C, 1'b0, '0, '0, 40);
    drain(80);
    chk("stall_err", last_err, TMO_ON);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          logic [AW-1:0] a;
          a = AW'($urandom_range(0, 15)) << 2;
          if ($urandom_range(0, 7) == 0) a = a + AW'($urandom_range(1, 3));
          req(i, a, 1'($urandom_range(0, 1)), $urandom,
              SW'($urandom_range(0, 15)), $urandom_range(0, 3));
        end
      end
      step();
    end
    drain(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
